// File: rtl/multi_mode_timer.sv
// multi_mode_timer: mm.ss run/pause/clear timer with BCD preset, countdown
// alarm, configurable minute limit (wrap or saturate) and a 4-digit display
// scanner feeding the seven-segment decoder.
module multi_mode_timer #(
    parameter int TICK_MAX   = 11999999,
    parameter int TICK_WIDTH = 24,
    parameter int SCAN_MAX   = 11999,
    parameter int SCAN_WIDTH = 17,
    parameter int MIN_MAX    = 59,
    parameter int WRAP       = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START_STOP,
    input  logic        CLEAR,
    input  logic        LOAD,
    input  logic        DIR_IN,
    input  logic [15:0] PRESET,
    output logic [15:0] BCD_OUT,
    output logic [3:0]  SEG_SELECT,
    output logic [3:0]  DIGIT,
    output logic        DOT,
    output logic        RUNNING,
    output logic        ALARM,
    output logic        CARRY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [6:0]            MIN_MAX_B   = 7'(MIN_MAX);
    localparam logic [7:0]            MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam logic [TICK_WIDTH-1:0] TICK_LAST   = TICK_WIDTH'(TICK_MAX);
    localparam logic [SCAN_WIDTH-1:0] SCAN_LAST   = SCAN_WIDTH'(SCAN_MAX);

    // Input synchronisers: bit 0 start/stop, 1 clear, 2 load, 3 direction.
    logic [3:0] raw_in;
    logic [3:0] sync1_reg, sync2_reg;
    logic [2:0] sync3_reg;
    logic       start_edge, clear_edge, load_edge, dir_down;

    state_t                  state_reg, state_next;
    logic [15:0]             bcd_reg, bcd_next;
    logic [TICK_WIDTH-1:0]   tick_reg, tick_next;
    logic                    carry_reg, carry_next;
    logic                    running_reg, alarm_reg;

    logic [SCAN_WIDTH-1:0]   scan_reg;
    logic [1:0]              idx_reg;
    logic [3:0]              seg_reg, digit_reg;
    logic                    dot_reg;

    logic [3:0]  su, st, mu, mt;
    logic [6:0]  minutes;
    logic        at_top, at_zero, at_one, tick_hit;
    logic [15:0] up_val, down_val;

    logic [15:0] digit_clamp;
    logic [3:0]  st_clamp;
    logic [6:0]  preset_min;
    logic [15:0] preset_clamped;

    assign raw_in     = {DIR_IN, LOAD, CLEAR, START_STOP};
    assign start_edge = sync2_reg[0] & ~sync3_reg[0];
    assign clear_edge = sync2_reg[1] & ~sync3_reg[1];
    assign load_edge  = sync2_reg[2] & ~sync3_reg[2];
    assign dir_down   = sync2_reg[3];

    // Two-flop synchroniser plus one delay flop per button for edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg[2:0];
        end
    end

    // Preset clamp: each digit to 9, seconds tens to 5, minutes to the limit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_clamp
            assign digit_clamp[gi*4 +: 4] = (PRESET[gi*4 +: 4] > 4'd9) ? 4'd9 : PRESET[gi*4 +: 4];
        end
    endgenerate

    assign st_clamp   = (digit_clamp[7:4] > 4'd5) ? 4'd5 : digit_clamp[7:4];
    assign preset_min = {3'b000, digit_clamp[15:12]} * 7'd10 + {3'b000, digit_clamp[11:8]};
    assign preset_clamped = {(preset_min > MIN_MAX_B) ? MIN_MAX_BCD : digit_clamp[15:8],
                             st_clamp, digit_clamp[3:0]};

    // Current count split into BCD digits and boundary decodes.
    assign su       = bcd_reg[3:0];
    assign st       = bcd_reg[7:4];
    assign mu       = bcd_reg[11:8];
    assign mt       = bcd_reg[15:12];
    assign minutes  = {3'b000, mt} * 7'd10 + {3'b000, mu};
    assign at_top   = (minutes == MIN_MAX_B) && (st == 4'd5) && (su == 4'd9);
    assign at_zero  = (bcd_reg == 16'h0000);
    assign at_one   = (bcd_reg == 16'h0001);
    assign tick_hit = (tick_reg == TICK_LAST);

    // BCD increment with ripple carry through sec units, sec tens, minutes.
    always_comb begin
        up_val = bcd_reg;
        if (su != 4'd9) begin
            up_val[3:0] = su + 4'd1;
        end else begin
            up_val[3:0] = 4'd0;
            if (st != 4'd5) begin
                up_val[7:4] = st + 4'd1;
            end else begin
                up_val[7:4] = 4'd0;
                if (mu != 4'd9) begin
                    up_val[11:8] = mu + 4'd1;
                end else begin
                    up_val[11:8]  = 4'd0;
                    up_val[15:12] = mt + 4'd1;
                end
            end
        end
    end

    // BCD decrement with borrow; never used at 00:00.
    always_comb begin
        down_val = bcd_reg;
        if (su != 4'd0) begin
            down_val[3:0] = su - 4'd1;
        end else begin
            down_val[3:0] = 4'd9;
            if (st != 4'd0) begin
                down_val[7:4] = st - 4'd1;
            end else begin
                down_val[7:4] = 4'd5;
                if (mu != 4'd0) begin
                    down_val[11:8] = mu - 4'd1;
                end else begin
                    down_val[11:8]  = 4'd9;
                    down_val[15:12] = mt - 4'd1;
                end
            end
        end
    end

    // Control FSM: next state, next count, tick prescaler and wrap carry.
    always_comb begin
        state_next = state_reg;
        bcd_next   = bcd_reg;
        tick_next  = tick_reg;
        carry_next = 1'b0;
        if (clear_edge) begin
            state_next = IDLE;
            bcd_next   = '0;
            tick_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_edge) begin
                        bcd_next = preset_clamped;
                    end else if (start_edge) begin
                        state_next = RUN;
                        tick_next  = '0;
                    end
                end
                RUN: begin
                    if (start_edge) begin
                        // Pausing freezes the tick phase so a resume continues it.
                        state_next = PAUSED;
                    end else if (tick_hit) begin
                        tick_next = '0;
                        if (!dir_down) begin
                            if (at_top) begin
                                if (WRAP != 0) begin
                                    bcd_next   = '0;
                                    carry_next = 1'b1;
                                end else begin
                                    state_next = EXPIRED;
                                end
                            end else begin
                                bcd_next = up_val;
                            end
                        end else if (at_zero) begin
                            state_next = EXPIRED;
                        end else begin
                            bcd_next = down_val;
                            if (at_one) begin
                                state_next = EXPIRED;
                            end
                        end
                    end else begin
                        tick_next = tick_reg + TICK_WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (start_edge) begin
                        state_next = RUN;
                    end
                end
                EXPIRED: begin
                    if (start_edge) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Timer state registers and registered status decodes of the state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            bcd_reg     <= '0;
            tick_reg    <= '0;
            carry_reg   <= 1'b0;
            running_reg <= 1'b0;
            alarm_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bcd_reg     <= bcd_next;
            tick_reg    <= tick_next;
            carry_reg   <= carry_next;
            running_reg <= (state_reg == RUN);
            alarm_reg   <= (state_reg == EXPIRED);
        end
    end

    // Free-running display scan with registered digit enable, value and dot.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scan_reg  <= '0;
            idx_reg   <= 2'd0;
            seg_reg   <= 4'b1110;
            digit_reg <= 4'd0;
            dot_reg   <= 1'b0;
        end else begin
            if (scan_reg == SCAN_LAST) begin
                scan_reg <= '0;
                idx_reg  <= idx_reg + 2'd1;
            end else begin
                scan_reg <= scan_reg + SCAN_WIDTH'(1);
            end
            seg_reg   <= ~(4'b0001 << idx_reg);
            digit_reg <= bcd_reg[{idx_reg, 2'b00} +: 4];
            dot_reg   <= (idx_reg == 2'd2);
        end
    end

    assign BCD_OUT    = bcd_reg;
    assign SEG_SELECT = seg_reg;
    assign DIGIT      = digit_reg;
    assign DOT        = dot_reg;
    assign RUNNING    = running_reg;
    assign ALARM      = alarm_reg;
    assign CARRY      = carry_reg;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed testbench for multi_mode_timer: a wrapping instance and a
// saturating instance share the same stimulus; expected values are hand-derived.
module tb_multi_mode_timer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START_STOP, CLEAR, LOAD, DIR_IN;
    logic [15:0] PRESET;

    logic [15:0] bcd_w, nw_bcd;
    logic [3:0]  seg_w, nw_seg, digit_w, nw_digit;
    logic        dot_w, nw_dot, running_w, nw_running, alarm_w, nw_alarm, carry_w, nw_carry;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    multi_mode_timer #(
        .TICK_MAX(3), .TICK_WIDTH(24), .SCAN_MAX(1), .SCAN_WIDTH(17), .MIN_MAX(59), .WRAP(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START_STOP(START_STOP), .CLEAR(CLEAR), .LOAD(LOAD),
        .DIR_IN(DIR_IN), .PRESET(PRESET), .BCD_OUT(bcd_w), .SEG_SELECT(seg_w),
        .DIGIT(digit_w), .DOT(dot_w), .RUNNING(running_w), .ALARM(alarm_w), .CARRY(carry_w)
    );

    multi_mode_timer #(
        .TICK_MAX(3), .TICK_WIDTH(24), .SCAN_MAX(1), .SCAN_WIDTH(17), .MIN_MAX(59), .WRAP(0)
    ) dut_nw (
        .CLK(CLK), .RESET(RESET), .START_STOP(START_STOP), .CLEAR(CLEAR), .LOAD(LOAD),
        .DIR_IN(DIR_IN), .PRESET(PRESET), .BCD_OUT(nw_bcd), .SEG_SELECT(nw_seg),
        .DIGIT(nw_digit), .DOT(nw_dot), .RUNNING(nw_running), .ALARM(nw_alarm), .CARRY(nw_carry)
    );

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Hold the selected buttons {LOAD, CLEAR, START_STOP} for three cycles;
    // the action lands on the third rising edge, just before this returns.
    task automatic press(input logic [2:0] btns);
        {LOAD, CLEAR, START_STOP} = btns;
        wait_cycles(3);
        {LOAD, CLEAR, START_STOP} = 3'b000;
    endtask

    logic [15:0] clamp_in  [3] = '{16'h9A7F, 16'h7342, 16'h0860};
    logic [15:0] clamp_exp [3] = '{16'h5959, 16'h5942, 16'h0850};
    logic [3:0]  seg_exp   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0]  dig_exp   [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0]  prev_seg;
    logic        found;

    initial begin
        RESET = 1'b1;
        {LOAD, CLEAR, START_STOP} = 3'b000;
        DIR_IN = 1'b0;
        PRESET = 16'h0000;
        wait_cycles(3);
        check_value("rst_bcd", bcd_w, 16'h0000);
        check_value("rst_seg", {12'h0, seg_w}, 16'h000E);
        check_value("rst_digit", {12'h0, digit_w}, 16'h0000);
        check_value("rst_flags", {12'h0, dot_w, running_w, alarm_w, carry_w}, 16'h0000);
        RESET = 1'b0;
        wait_cycles(3);

        // 1: count up from idle, first step 4 cycles after entering RUN
        DIR_IN = 1'b0;
        press(3'b001);
        wait_cycles(3);
        check_value("t1_before_step", bcd_w, 16'h0000);
        wait_cycles(1);
        check_value("t1_first_step", bcd_w, 16'h0001);
        check_value("t1_running", {15'h0, running_w}, 16'h0001);
        wait_cycles(35);
        check_value("t1_nine", bcd_w, 16'h0009);
        wait_cycles(1);
        check_value("t1_ten", bcd_w, 16'h0010);
        press(3'b010);
        check_value("t1_clear", bcd_w, 16'h0000);
        wait_cycles(3);

        // 2: countdown from a preset into EXPIRED, then START back to IDLE
        PRESET = 16'h0002;
        DIR_IN = 1'b1;
        press(3'b100);
        check_value("t2_load", bcd_w, 16'h0002);
        wait_cycles(3);
        press(3'b001);
        wait_cycles(3);
        check_value("t2_hold", bcd_w, 16'h0002);
        wait_cycles(1);
        check_value("t2_one", bcd_w, 16'h0001);
        wait_cycles(4);
        check_value("t2_zero", bcd_w, 16'h0000);
        wait_cycles(1);
        check_value("t2_alarm", {14'h0, alarm_w, running_w}, 16'h0002);
        wait_cycles(10);
        check_value("t2_expired_hold", {alarm_w, 15'h0} | bcd_w, 16'h8000);
        press(3'b001);
        wait_cycles(1);
        check_value("t2_back_idle", {14'h0, alarm_w, running_w}, 16'h0000);
        check_value("t2_idle_count", bcd_w, 16'h0000);
        wait_cycles(3);

        // 3: up-count at the top: wrap with carry vs saturate and expire
        PRESET = 16'h5959;
        DIR_IN = 1'b0;
        press(3'b100);
        check_value("t3_load", bcd_w, 16'h5959);
        check_value("t3_load_nw", nw_bcd, 16'h5959);
        wait_cycles(3);
        press(3'b001);
        wait_cycles(3);
        check_value("t3_pre_top", bcd_w, 16'h5959);
        check_value("t3_pre_carry", {15'h0, carry_w}, 16'h0000);
        wait_cycles(1);
        check_value("t3_wrap", bcd_w, 16'h0000);
        check_value("t3_carry", {15'h0, carry_w}, 16'h0001);
        check_value("t3_nw_hold", nw_bcd, 16'h5959);
        wait_cycles(1);
        check_value("t3_carry_end", {14'h0, carry_w, running_w}, 16'h0001);
        check_value("t3_nw_alarm", {14'h0, nw_alarm, nw_running}, 16'h0002);
        check_value("t3_nw_value", nw_bcd, 16'h5959);
        check_value("t3_nw_no_carry", {15'h0, nw_carry}, 16'h0000);
        press(3'b010);
        wait_cycles(3);

        // 4: preset clamping, and LOAD ignored while running
        for (int i = 0; i < 3; i++) begin
            PRESET = clamp_in[i];
            press(3'b100);
            check_value($sformatf("t4_clamp_%0d", i), bcd_w, clamp_exp[i]);
            wait_cycles(3);
        end
        PRESET = 16'h9A7F;
        press(3'b100);
        wait_cycles(3);
        press(3'b001);
        PRESET = 16'h0002;
        press(3'b100);
        check_value("t4_load_in_run", bcd_w, 16'h5959);
        check_value("t4_load_in_run_nw", nw_bcd, 16'h5959);
        wait_cycles(1);
        check_value("t4_run_continues", bcd_w, 16'h0000);
        press(3'b010);
        wait_cycles(3);

        // 5: pause freezes count and tick phase; resume keeps the residual
        press(3'b001);
        wait_cycles(12);
        check_value("t5_three", bcd_w, 16'h0003);
        press(3'b001);
        wait_cycles(50);
        check_value("t5_paused_count", bcd_w, 16'h0003);
        check_value("t5_paused_flag", {15'h0, running_w}, 16'h0000);
        press(3'b001);
        wait_cycles(1);
        check_value("t5_residual_hold", bcd_w, 16'h0003);
        wait_cycles(1);
        check_value("t5_residual_step", bcd_w, 16'h0004);
        wait_cycles(3);
        press(3'b011);
        check_value("t5_clear_wins", bcd_w, 16'h0000);
        wait_cycles(10);
        check_value("t5_clear_idle", {running_w, 15'h0} | bcd_w, 16'h0000);

        // 6: display scan of 12:34 and asynchronous reset mid-scan
        PRESET = 16'h1234;
        press(3'b100);
        check_value("t6_load", bcd_w, 16'h1234);
        found = 1'b0;
        prev_seg = seg_w;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (seg_w == 4'b1110 && prev_seg != 4'b1110) found = 1'b1;
            prev_seg = seg_w;
        end
        check_value("t6_scan_found", {15'h0, found}, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge CLK);
            check_value($sformatf("t6_seg_%0d", k), {12'h0, seg_w}, {12'h0, seg_exp[k/2]});
            check_value($sformatf("t6_digit_%0d", k), {12'h0, digit_w}, {12'h0, dig_exp[k/2]});
            check_value($sformatf("t6_dot_%0d", k), {15'h0, dot_w}, {15'h0, (k/2 == 2)});
        end
        #1 RESET = 1'b1;
        #1;
        check_value("t6_rst_seg", {12'h0, seg_w}, 16'h000E);
        check_value("t6_rst_digit", {12'h0, digit_w}, 16'h0000);
        check_value("t6_rst_bcd", bcd_w, 16'h0000);
        wait_cycles(3);
        RESET = 1'b0;
        wait_cycles(5);
        check_value("t6_post_reset", {running_w, alarm_w, 14'h0} | bcd_w, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
